data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache, instantiated inside the MEM stage between the EX/MEM register outputs and main memory.
- Serves byte, halfword and word loads and stores using RISC-V funct3 addressing modes.
- Drives the global `stall` that freezes all pipeline registers while it services main memory.
- Talks to main memory through a single-beat request/ready handshake.

Parameters:
SETS, 64, number of lines (power of 2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2)
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width (fixed at 32)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cpu_read  in  1  load request in MEM stage
cpu_write  in  1  store request in MEM stage
cpu_addr  in  ADDR_WIDTH  byte address (ALU result)
cpu_wdata  in  32  store data, in lane 0
cpu_mode  in  3  funct3 addressing mode
cpu_rdata  out  32  extended load data
stall  out  1  pipeline freeze request
mem_req  out  1  memory access valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned memory address
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables for writes
mem_ready  in  1  memory completes the current access this cycle
mem_rdata  in  32  read word, valid when mem_ready

Behaviour:
- Address split (defaults): [1:0] byte, [3:2] word, [9:4] index, [31:10] tag. Split derived from parameters.
- Storage: valid bit and tag per set; data words in a register array.
- Hit: valid[index] and tag match.
- Reset (rst low, asynchronous):
  - all valid bits clear; state IDLE; beat counter 0; wr_done 0.
  - mem_req = 0, mem_we = 0, mem_wstrb = 0, cpu_rdata = 0, stall = 0 with no request.
- FSM states: IDLE, REFILL, WRITE_MEM.
- IDLE:
  - Read hit: cpu_rdata is combinational from the array; stall = 0; 0-cycle latency.
  - Read miss: stall = 1 combinationally the same cycle; next state REFILL; beat counter = 0.
  - Write: stall = cpu_write & ~wr_done. If wr_done = 0, next state WRITE_MEM.
  - If cpu_read and cpu_write are both high, the write takes priority.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, counter, 2'b00}; stall = 1.
  - On mem_ready: store mem_rdata into word[counter]; counter increments.
  - On the last beat: set valid and tag; go to IDLE.
  - The next IDLE cycle is a hit and releases the stall.
  - Beats are fetched in order from word 0; there is no critical-word-first.
- WRITE_MEM:
  - mem_req = 1, mem_we = 1, mem_addr = cpu_addr word-aligned; stall = 1.
  - On mem_ready: if hit, merge enabled bytes into the cached word; set wr_done = 1; go to IDLE.
  - On a miss the line is left untouched (no allocate).
- wr_done:
  - Clears on the cycle after it is set, unconditionally.
  - This gives exactly one stall-free cycle, so the pipeline retires the store without re-issuing it.
- Memory handshake: mem_req, mem_addr, mem_we and mem_wstrb hold stable until mem_ready. mem_ready while mem_req = 0 is ignored.
- Load extension (lane chosen by byte offset):
  - 000 LB: sign-extend byte at addr[1:0].
  - 001 LH: sign-extend half at addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes return the full word.
  - Misalignment is not trapped: addr[0] is ignored for halves, addr[1:0] for words.
- Store strobes:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1], 1'b0}.
  - SW: 4'b1111.
  - mem_wdata replicates the byte or half into every lane.
- cpu_rdata is 0 when cpu_read is low.
- Reset mid-REFILL aborts the refill; the line stays invalid and mem_req drops immediately.

Test Plan:
1. Cold read miss, LW 0x100, memory word n = 0xA0+n, mem_ready tied 1 -> stall high 5 cycles; mem_addr 0x100, 0x104, 0x108, 0x10C; cycle 5 stall = 0, cpu_rdata = 0xA0.
2. After scenario 1: LW 0x108, then LB 0x10B with word 0x808080A2 at 0x108 -> each has stall = 0 and no mem_req; LB returns 0xFFFFFF80, LBU returns 0x00000080.
3. SB 0x101, data 0x5A, line resident, ready tied 1 -> stall 2 cycles; mem_wstrb = 0010, mem_wdata = 0x5A5A5A5A; subsequent LW 0x100 hits with byte 1 = 0x5A.
4. SH 0x406 (not cached), mem_ready delayed 3 cycles -> mem_req held stable for 4 cycles with strobe 1100; no refill; LW 0x404 then misses.
5. Read miss with mem_ready pulsed every other cycle -> exactly 4 beats are consumed and stall deasserts one cycle after the 4th ready.
6. rst low during beat 2 of a refill -> mem_req = 0 immediately; after release, LW to the same address misses again and performs 4 beats.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache for the MEM stage.
// Loads hit in zero cycles; misses refill a whole line in order, stores always go to memory.
module data_cache #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_mode,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = IDX_W + WORD_W + 2;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM} state_t;

  state_t                  r_state;
  logic [WORD_W-1:0]       r_cnt;
  logic                    r_wr_done;
  logic [SETS-1:0]         r_valid;
  logic [TAG_W-1:0]        r_tag  [SETS];
  logic [DATA_WIDTH-1:0]   r_data [SETS*WORDS_PER_LINE];

  logic [WORD_W-1:0]       w_word;
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic [DATA_WIDTH-1:0]   w_cached;
  logic [3:0]              w_strb;
  logic [DATA_WIDTH-1:0]   w_wdata_rep;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] mode);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (mode)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'b0, b};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] mode, input logic [1:0] off);
    case (mode)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << {off[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] mode, input logic [31:0] d);
    case (mode)
      2'b00:   store_rep = {4{d[7:0]}};
      2'b01:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  assign w_word      = cpu_addr[WORD_W+1:2];
  assign w_idx       = cpu_addr[TAG_LSB-1:WORD_W+2];
  assign w_tag       = cpu_addr[ADDR_WIDTH-1:TAG_LSB];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_cached    = r_data[{w_idx, w_word}];
  assign w_strb      = store_strb(cpu_mode[1:0], cpu_addr[1:0]);
  assign w_wdata_rep = store_rep(cpu_mode[1:0], cpu_wdata);
  assign mem_wdata   = w_wdata_rep;
  assign cpu_rdata   = cpu_read ? load_ext(w_cached, cpu_addr[1:0], cpu_mode) : '0;

  // Control state: reset aborts any refill in flight and invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr_done <= 1'b0;
      r_valid   <= '0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_write) begin
            if (!r_wr_done) r_state <= WRITE_MEM;
          end else if (cpu_read && !w_hit) begin
            r_state        <= REFILL;
            r_cnt          <= '0;
            r_valid[w_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_valid[w_idx] <= 1'b1;
              r_state        <= IDLE;
            end
          end
        end
        WRITE_MEM: begin
          if (mem_ready) begin
            r_wr_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; validity alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (r_state == REFILL && mem_ready) begin
      r_data[{w_idx, r_cnt}] <= mem_rdata;
      if (r_cnt == LAST_BEAT) r_tag[w_idx] <= w_tag;
    end
    if (r_state == WRITE_MEM && mem_ready && w_hit)
      r_data[{w_idx, w_word}] <= merge_bytes(w_cached, w_wdata_rep, w_strb);
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    stall     = 1'b0;
    case (r_state)
      IDLE:      stall = cpu_write ? !r_wr_done : (cpu_read && !w_hit);
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
        stall    = 1'b1;
      end
      WRITE_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wstrb = w_strb;
        stall     = 1'b1;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule
